tl_buffer_ad: RTL and testbench
===============================

TL_BUFFER_AD -- requirements
Module: tl_buffer_ad

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, entries per channel queue; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port auto_in_a_valid/auto_in_a_ready, in/out, 1/1 bits: A request handshake from the crossbar out port.
REQ-005 The block SHALL have port auto_in_a_bits_{opcode,param,size,source,address,mask,data}, input, 3/3/4/5/33/8/64 bits: A payload.
REQ-006 The block SHALL have port auto_out_a_valid/auto_out_a_ready, out/in, 1/1 bits: A handshake toward the slave.
REQ-007 The block SHALL have port auto_out_a_bits_*, output, same fields and widths as REQ-005: buffered A payload.
REQ-008 The block SHALL have port auto_out_d_valid/auto_out_d_ready, in/out, 1/1 bits: D response handshake from the slave.
REQ-009 The block SHALL have port auto_out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}, input, 3/2/4/5/2/1/64/1 bits: D payload.
REQ-010 The block SHALL have port auto_in_d_valid/auto_in_d_ready, out/in, 1/1 bits: D handshake toward the crossbar.
REQ-011 The block SHALL have port auto_in_d_bits_*, output, same fields and widths as REQ-009: buffered D payload.

Function
REQ-012 The block SHALL hold each channel in an independent FIFO of DEPTH entries: write pointer, read pointer and count of width log2(DEPTH)+1.
REQ-013 A beat SHALL be enqueued when in-side valid & ready and dequeued when out-side valid & ready; payload is stored verbatim, no field is modified.
REQ-014 The in-side ready SHALL equal (count != DEPTH); a full queue SHALL NOT be written, and no enqueue in the same cycle as a full-queue dequeue (no pass-through when full).
REQ-015 The out-side valid SHALL equal (count != 0) and the out-side payload SHALL be the entry at the read pointer; data SHALL be held stable while valid & !ready.
REQ-016 With the flow feature absent, latency SHALL be exactly 1 cycle from in-side handshake to out-side valid on an empty queue.
REQ-017 Simultaneous enqueue and dequeue on a non-empty, non-full queue SHALL leave count unchanged and advance both pointers.
REQ-018 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-019 Ordering SHALL be strict FIFO per channel; A and D SHALL not interact (a D beat may overtake nothing and be blocked by nothing on A).
REQ-020 Multi-beat bursts (A PutFullData, D AccessAckData) SHALL be passed beat-by-beat with no burst-level locking; the buffer is burst-agnostic.
REQ-021 In non-synthesis builds, the block SHALL fire an error and $fatal if out-side payload changes while out-side valid & !ready, or if a write occurs while count == DEPTH.

Reset
REQ-022 Asserting reset SHALL immediately clear both pointers and counts, forcing auto_out_a_valid=0, auto_in_d_valid=0, auto_in_a_ready=1, auto_out_d_ready=1.
REQ-023 Reset mid-operation SHALL discard all queued beats; storage contents SHALL not be reset and are don't-care.
REQ-024 The first enqueue SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro TL_BUFFER_D_FLOW_EN SHALL control the D queue flow mode.
REQ-026 With TL_BUFFER_D_FLOW_EN defined, the D queue SHALL present auto_out_d_* combinationally on auto_in_d_* when empty, with zero latency, and SHALL not enqueue a beat consumed in that same cycle.
REQ-027 Without TL_BUFFER_D_FLOW_EN, the D queue SHALL behave as in REQ-016; the A queue SHALL never flow through.

Verification
REQ-028 Reset released, A beat opcode=4 source=5'h10 address=33'h8000_0000 enqueued at cycle 0, out ready=1 -> auto_out_a_valid=1 at cycle 1 with identical fields; 0 at cycle 2.
REQ-029 DEPTH=2, out_a_ready=0, three A beats offered -> two accepted, auto_in_a_ready=0 from cycle 2; release ready -> beats drain in order, ready returns to 1 one cycle after first dequeue.
REQ-030 Continuous traffic, both sides ready=1, 8-beat PutFullData data 0..7 -> 1 beat per cycle throughput, output data 0..7 in order, count constant at 1.
REQ-031 D queue full (2 beats), reset asserted mid-cycle -> auto_in_d_valid falls immediately without a clock edge; after release new beat source=5'h03 emerges first.
REQ-032 TL_BUFFER_D_FLOW_EN defined, empty D queue, auto_out_d_valid=1 denied=1, auto_in_d_ready=1 -> auto_in_d_valid=1 same cycle, denied=1, count stays 0.
REQ-033 Random valid/ready on both channels, 10000 cycles -> scoreboard shows no loss, duplication or reorder; REQ-021 checks never fire.

Source files
------------

// File: rtl/tl_buffer_ad_if.sv
// ---------------------------------------------------------------------------
// tl_buffer_ad_if -- one TileLink-UL link carrying an A (request) channel
// and a D (response) channel.
//
// master modport: drives A (valid + bits), accepts D (drives d_ready).
// slave  modport: accepts A (drives a_ready), drives D (valid + bits).
//
// A bits : opcode[2:0] param[2:0] size[3:0] source[4:0] address[32:0]
//          mask[7:0] data[63:0]
// D bits : opcode[2:0] param[1:0] size[3:0] source[4:0] sink[1:0]
//          denied data[63:0] corrupt
// ---------------------------------------------------------------------------
interface tl_buffer_ad_if;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_bits_opcode;
   logic [2:0]  a_bits_param;
   logic [3:0]  a_bits_size;
   logic [4:0]  a_bits_source;
   logic [32:0] a_bits_address;
   logic [7:0]  a_bits_mask;
   logic [63:0] a_bits_data;

   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_bits_opcode;
   logic [1:0]  d_bits_param;
   logic [3:0]  d_bits_size;
   logic [4:0]  d_bits_source;
   logic [1:0]  d_bits_sink;
   logic        d_bits_denied;
   logic [63:0] d_bits_data;
   logic        d_bits_corrupt;

   modport master (
      output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data,
      input  a_ready,
      input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
             d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
      output d_ready
   );

   modport slave (
      input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data,
      output a_ready,
      output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
             d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
      input  d_ready
   );
endinterface

// File: rtl/tl_buffer_ad.sv
// ---------------------------------------------------------------------------
// tl_buffer_ad -- TileLink A/D channel buffer.
//
// Each channel passes through its own DEPTH-entry FIFO. Payloads are stored
// verbatim; the buffer is burst-agnostic and the two channels never interact.
//
// Ports:
//   clock    : single clock, rising edge
//   reset    : asynchronous, active-high; clears pointers and counts only
//   auto_in  : slave side facing the crossbar (A in, D out)
//   auto_out : master side facing the slave   (A out, D in)
//
// Parameter DEPTH : entries per channel queue (2, 4 or 8).
//
// Macro TL_BUFFER_D_FLOW_EN : when defined, an empty D queue forwards the
// incoming D beat combinationally (zero latency) and does not store a beat
// that is consumed in the same cycle. The A queue never flows through.
// ---------------------------------------------------------------------------
module tl_buffer_ad #(
   parameter int DEPTH = 2
) (
   input logic            clock,
   input logic            reset,
   tl_buffer_ad_if.slave  auto_in,
   tl_buffer_ad_if.master auto_out
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int AW = 120;
   localparam int DW = 82;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   // ---------------- A channel ----------------
   logic [AW-1:0] a_mem_q [DEPTH];
   logic [PW-1:0] a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d, a_cnt_q, a_cnt_d;
   logic [AW-1:0] a_wdata, a_rdata;
   logic          a_enq, a_deq;

   assign a_wdata = {auto_in.a_bits_opcode, auto_in.a_bits_param, auto_in.a_bits_size,
                     auto_in.a_bits_source, auto_in.a_bits_address, auto_in.a_bits_mask,
                     auto_in.a_bits_data};
   assign a_rdata = a_mem_q[a_rptr_q[IW-1:0]];

   assign auto_in.a_ready  = (a_cnt_q != FULL);
   assign auto_out.a_valid = (a_cnt_q != '0);
   assign {auto_out.a_bits_opcode, auto_out.a_bits_param, auto_out.a_bits_size,
           auto_out.a_bits_source, auto_out.a_bits_address, auto_out.a_bits_mask,
           auto_out.a_bits_data} = a_rdata;

   assign a_enq = auto_in.a_valid & auto_in.a_ready;
   assign a_deq = auto_out.a_valid & auto_out.a_ready;

   always_comb begin
      a_wptr_d = a_wptr_q + PW'(a_enq);
      a_rptr_d = a_rptr_q + PW'(a_deq);
      a_cnt_d  = a_cnt_q + PW'(a_enq) - PW'(a_deq);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_wptr_q <= '0;
         a_rptr_q <= '0;
         a_cnt_q  <= '0;
      end else begin
         a_wptr_q <= a_wptr_d;
         a_rptr_q <= a_rptr_d;
         a_cnt_q  <= a_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (a_enq) a_mem_q[a_wptr_q[IW-1:0]] <= a_wdata;
   end

   // ---------------- D channel ----------------
   logic [DW-1:0] d_mem_q [DEPTH];
   logic [PW-1:0] d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d, d_cnt_q, d_cnt_d;
   logic [DW-1:0] d_wdata, d_rdata, d_obits;
   logic          d_enq, d_deq;

   assign d_wdata = {auto_out.d_bits_opcode, auto_out.d_bits_param, auto_out.d_bits_size,
                     auto_out.d_bits_source, auto_out.d_bits_sink, auto_out.d_bits_denied,
                     auto_out.d_bits_data, auto_out.d_bits_corrupt};
   assign d_rdata = d_mem_q[d_rptr_q[IW-1:0]];

   assign auto_out.d_ready = (d_cnt_q != FULL);

`ifdef TL_BUFFER_D_FLOW_EN
   logic d_flow;
   assign d_flow = (d_cnt_q == '0);
   // Reset gates the bypass so the crossbar sees no D beat while in reset.
   assign auto_in.d_valid = d_flow ? (auto_out.d_valid & ~reset) : 1'b1;
   assign d_obits         = d_flow ? d_wdata : d_rdata;
   // A bypassed beat taken this cycle must not also be stored.
   assign d_enq = auto_out.d_valid & auto_out.d_ready & ~(d_flow & auto_in.d_ready);
   assign d_deq = auto_in.d_ready & ~d_flow;
`else
   assign auto_in.d_valid = (d_cnt_q != '0);
   assign d_obits         = d_rdata;
   assign d_enq = auto_out.d_valid & auto_out.d_ready;
   assign d_deq = auto_in.d_valid & auto_in.d_ready;
`endif

   assign {auto_in.d_bits_opcode, auto_in.d_bits_param, auto_in.d_bits_size,
           auto_in.d_bits_source, auto_in.d_bits_sink, auto_in.d_bits_denied,
           auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_obits;

   always_comb begin
      d_wptr_d = d_wptr_q + PW'(d_enq);
      d_rptr_d = d_rptr_q + PW'(d_deq);
      d_cnt_d  = d_cnt_q + PW'(d_enq) - PW'(d_deq);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d_wptr_q <= '0;
         d_rptr_q <= '0;
         d_cnt_q  <= '0;
      end else begin
         d_wptr_q <= d_wptr_d;
         d_rptr_q <= d_rptr_d;
         d_cnt_q  <= d_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (d_enq) d_mem_q[d_wptr_q[IW-1:0]] <= d_wdata;
   end

`ifndef SYNTHESIS
   // Protocol checks: output payload must hold while stalled, and a full
   // queue must never be written.
   logic          a_stall_q, d_stall_q;
   logic [AW-1:0] a_seen_q;
   logic [DW-1:0] d_seen_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_stall_q <= 1'b0;
         d_stall_q <= 1'b0;
      end else begin
         a_stall_q <= auto_out.a_valid & ~auto_out.a_ready;
         d_stall_q <= auto_in.d_valid & ~auto_in.d_ready;
      end
   end

   always_ff @(posedge clock) begin
      a_seen_q <= a_rdata;
      d_seen_q <= d_obits;
   end

   always @(posedge clock) begin
      if (!reset && a_stall_q && auto_out.a_valid && (a_rdata != a_seen_q)) begin
         $error("tl_buffer_ad: A payload changed while stalled");
         $fatal(1, "tl_buffer_ad: A stability violation");
      end
      if (!reset && d_stall_q && auto_in.d_valid && (d_obits != d_seen_q)) begin
         $error("tl_buffer_ad: D payload changed while stalled");
         $fatal(1, "tl_buffer_ad: D stability violation");
      end
      if (!reset && ((a_enq && a_cnt_q == FULL) || (d_enq && d_cnt_q == FULL))) begin
         $error("tl_buffer_ad: write into full queue");
         $fatal(1, "tl_buffer_ad: overflow");
      end
   end
`endif
endmodule

// File: tb/tb_tl_buffer_ad.sv
module tb_tl_buffer_ad;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tl_buffer_ad_if in_if ();
   tl_buffer_ad_if out_if ();

   tl_buffer_ad #(.DEPTH(2)) dut (
      .clock   (clk),
      .reset   (rst),
      .auto_in (in_if),
      .auto_out(out_if)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;

   function automatic logic [119:0] pk_a_in();
      return {in_if.a_bits_opcode, in_if.a_bits_param, in_if.a_bits_size, in_if.a_bits_source,
              in_if.a_bits_address, in_if.a_bits_mask, in_if.a_bits_data};
   endfunction
   function automatic logic [119:0] pk_a_out();
      return {out_if.a_bits_opcode, out_if.a_bits_param, out_if.a_bits_size, out_if.a_bits_source,
              out_if.a_bits_address, out_if.a_bits_mask, out_if.a_bits_data};
   endfunction
   function automatic logic [81:0] pk_d_in();
      return {out_if.d_bits_opcode, out_if.d_bits_param, out_if.d_bits_size, out_if.d_bits_source,
              out_if.d_bits_sink, out_if.d_bits_denied, out_if.d_bits_data, out_if.d_bits_corrupt};
   endfunction
   function automatic logic [81:0] pk_d_out();
      return {in_if.d_bits_opcode, in_if.d_bits_param, in_if.d_bits_size, in_if.d_bits_source,
              in_if.d_bits_sink, in_if.d_bits_denied, in_if.d_bits_data, in_if.d_bits_corrupt};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_if.a_valid = 1'b0;        in_if.a_bits_opcode = '0;  in_if.a_bits_param = '0;
      in_if.a_bits_size = '0;      in_if.a_bits_source = '0;  in_if.a_bits_address = '0;
      in_if.a_bits_mask = '0;      in_if.a_bits_data = '0;    in_if.d_ready = 1'b0;
      out_if.a_ready = 1'b0;       out_if.d_valid = 1'b0;     out_if.d_bits_opcode = '0;
      out_if.d_bits_param = '0;    out_if.d_bits_size = '0;   out_if.d_bits_source = '0;
      out_if.d_bits_sink = '0;     out_if.d_bits_denied = 1'b0;
      out_if.d_bits_data = '0;     out_if.d_bits_corrupt = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic rand_a();
      in_if.a_bits_opcode  = 3'($urandom);  in_if.a_bits_param = 3'($urandom);
      in_if.a_bits_size    = 4'($urandom);  in_if.a_bits_source = 5'($urandom);
      in_if.a_bits_address = {1'($urandom), 32'($urandom)};
      in_if.a_bits_mask    = 8'($urandom);
      in_if.a_bits_data    = {32'($urandom), 32'($urandom)};
   endtask

   task automatic rand_d();
      out_if.d_bits_opcode = 3'($urandom);  out_if.d_bits_param = 2'($urandom);
      out_if.d_bits_size   = 4'($urandom);  out_if.d_bits_source = 5'($urandom);
      out_if.d_bits_sink   = 2'($urandom);  out_if.d_bits_denied = 1'($urandom);
      out_if.d_bits_data   = {32'($urandom), 32'($urandom)};
      out_if.d_bits_corrupt = 1'($urandom);
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 rst = 1'b1;
      #1;
      chk_cnt++; if (out_if.a_valid !== 1'b0) $display("FAIL reset_out_a_valid got %b want 0", out_if.a_valid); else pass_cnt++;
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL reset_in_d_valid got %b want 0", in_if.d_valid); else pass_cnt++;
      chk_cnt++; if (in_if.a_ready !== 1'b1) $display("FAIL reset_in_a_ready got %b want 1", in_if.a_ready); else pass_cnt++;
      chk_cnt++; if (out_if.d_ready !== 1'b1) $display("FAIL reset_out_d_ready got %b want 1", out_if.d_ready); else pass_cnt++;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_a_single();
      do_reset();
      out_if.a_ready = 1'b1;
      in_if.a_valid = 1'b1;            in_if.a_bits_opcode = 3'd4;   in_if.a_bits_param = 3'd0;
      in_if.a_bits_size = 4'd3;        in_if.a_bits_source = 5'h10;
      in_if.a_bits_address = 33'h0_8000_0000;
      in_if.a_bits_mask = 8'hff;       in_if.a_bits_data = 64'h1122_3344_5566_7788;
      #1;
      chk_cnt++; if (in_if.a_ready !== 1'b1) $display("FAIL single_ready got %b want 1", in_if.a_ready); else pass_cnt++;
      chk_cnt++; if (out_if.a_valid !== 1'b0) $display("FAIL single_valid_c0 got %b want 0", out_if.a_valid); else pass_cnt++;
      step();
      in_if.a_valid = 1'b0;
      chk_cnt++; if (out_if.a_valid !== 1'b1) $display("FAIL single_valid_c1 got %b want 1", out_if.a_valid); else pass_cnt++;
      chk_cnt++;
      if (pk_a_out() !== {3'd4, 3'd0, 4'd3, 5'h10, 33'h0_8000_0000, 8'hff, 64'h1122_3344_5566_7788})
         $display("FAIL single_fields got %h want %h", pk_a_out(),
                  {3'd4, 3'd0, 4'd3, 5'h10, 33'h0_8000_0000, 8'hff, 64'h1122_3344_5566_7788});
      else pass_cnt++;
      step();
      chk_cnt++; if (out_if.a_valid !== 1'b0) $display("FAIL single_valid_c2 got %b want 0", out_if.a_valid); else pass_cnt++;
   endtask

   task automatic test_a_full();
      do_reset();
      out_if.a_ready = 1'b0;
      in_if.a_valid = 1'b1;
      in_if.a_bits_source = 5'd1;
      #1;
      chk_cnt++; if (in_if.a_ready !== 1'b1) $display("FAIL full_ready_c0 got %b want 1", in_if.a_ready); else pass_cnt++;
      step();
      in_if.a_bits_source = 5'd2;
      chk_cnt++; if (in_if.a_ready !== 1'b1) $display("FAIL full_ready_c1 got %b want 1", in_if.a_ready); else pass_cnt++;
      step();
      in_if.a_bits_source = 5'd3;
      chk_cnt++; if (in_if.a_ready !== 1'b0) $display("FAIL full_ready_c2 got %b want 0", in_if.a_ready); else pass_cnt++;
      step();
      chk_cnt++; if (in_if.a_ready !== 1'b0) $display("FAIL full_ready_c3 got %b want 0", in_if.a_ready); else pass_cnt++;
      chk_cnt++; if (out_if.a_bits_source !== 5'd1) $display("FAIL full_head got %0d want 1", out_if.a_bits_source); else pass_cnt++;
      out_if.a_ready = 1'b1;
      step();
      chk_cnt++; if (in_if.a_ready !== 1'b1) $display("FAIL full_ready_after_deq got %b want 1", in_if.a_ready); else pass_cnt++;
      chk_cnt++; if (out_if.a_bits_source !== 5'd2) $display("FAIL full_second got %0d want 2", out_if.a_bits_source); else pass_cnt++;
      step();
      in_if.a_valid = 1'b0;
      chk_cnt++; if (out_if.a_bits_source !== 5'd3 || out_if.a_valid !== 1'b1)
         $display("FAIL full_third got v=%b src=%0d want v=1 src=3", out_if.a_valid, out_if.a_bits_source);
      else pass_cnt++;
      step();
      chk_cnt++; if (out_if.a_valid !== 1'b0) $display("FAIL full_drained got %b want 0", out_if.a_valid); else pass_cnt++;
   endtask

   task automatic test_burst();
      do_reset();
      out_if.a_ready = 1'b1;
      in_if.a_valid = 1'b1;
      in_if.a_bits_opcode = 3'd0;
      in_if.a_bits_size = 4'd6;
      for (int i = 0; i < 8; i++) begin
         in_if.a_bits_data = 64'(i);
         step();
         chk_cnt++;
         if (out_if.a_valid !== 1'b1 || out_if.a_bits_data !== 64'(i) || in_if.a_ready !== 1'b1)
            $display("FAIL burst_beat%0d got v=%b d=%0d rdy=%b want v=1 d=%0d rdy=1",
                     i, out_if.a_valid, out_if.a_bits_data, in_if.a_ready, i);
         else pass_cnt++;
      end
      in_if.a_valid = 1'b0;
      step();
      chk_cnt++; if (out_if.a_valid !== 1'b0) $display("FAIL burst_end got %b want 0", out_if.a_valid); else pass_cnt++;
   endtask

`ifdef TL_BUFFER_D_FLOW_EN
   task automatic test_d_flow();
      do_reset();
      in_if.d_ready = 1'b1;
      out_if.d_valid = 1'b1;  out_if.d_bits_denied = 1'b1;  out_if.d_bits_source = 5'd7;
      #1;
      chk_cnt++; if (in_if.d_valid !== 1'b1) $display("FAIL flow_valid got %b want 1", in_if.d_valid); else pass_cnt++;
      chk_cnt++; if (in_if.d_bits_denied !== 1'b1 || in_if.d_bits_source !== 5'd7)
         $display("FAIL flow_fields got den=%b src=%0d want den=1 src=7", in_if.d_bits_denied, in_if.d_bits_source);
      else pass_cnt++;
      step();
      out_if.d_valid = 1'b0;
      #1;
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL flow_not_stored got %b want 0", in_if.d_valid); else pass_cnt++;
      chk_cnt++; if (out_if.d_ready !== 1'b1) $display("FAIL flow_ready got %b want 1", out_if.d_ready); else pass_cnt++;
   endtask
`else
   task automatic test_d_latency();
      do_reset();
      in_if.d_ready = 1'b1;
      out_if.d_valid = 1'b1;  out_if.d_bits_denied = 1'b1;  out_if.d_bits_source = 5'd7;
      #1;
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL dlat_c0 got %b want 0", in_if.d_valid); else pass_cnt++;
      step();
      out_if.d_valid = 1'b0;
      chk_cnt++; if (in_if.d_valid !== 1'b1) $display("FAIL dlat_c1 got %b want 1", in_if.d_valid); else pass_cnt++;
      chk_cnt++; if (in_if.d_bits_denied !== 1'b1 || in_if.d_bits_source !== 5'd7)
         $display("FAIL dlat_fields got den=%b src=%0d want den=1 src=7", in_if.d_bits_denied, in_if.d_bits_source);
      else pass_cnt++;
      step();
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL dlat_c2 got %b want 0", in_if.d_valid); else pass_cnt++;
   endtask
`endif

   task automatic test_d_reset_mid();
      do_reset();
      in_if.d_ready = 1'b0;
      out_if.d_valid = 1'b1;
      out_if.d_bits_source = 5'd1;
      step();
      out_if.d_bits_source = 5'd2;
      step();
      out_if.d_valid = 1'b0;
      chk_cnt++; if (out_if.d_ready !== 1'b0) $display("FAIL dres_full got %b want 0", out_if.d_ready); else pass_cnt++;
      chk_cnt++; if (in_if.d_valid !== 1'b1 || in_if.d_bits_source !== 5'd1)
         $display("FAIL dres_head got v=%b src=%0d want v=1 src=1", in_if.d_valid, in_if.d_bits_source);
      else pass_cnt++;
      #3 rst = 1'b1;
      #1;
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL dres_async_valid got %b want 0", in_if.d_valid); else pass_cnt++;
      chk_cnt++; if (out_if.d_ready !== 1'b1) $display("FAIL dres_async_ready got %b want 1", out_if.d_ready); else pass_cnt++;
      step();
      step();
      rst = 1'b0;
      out_if.d_valid = 1'b1;
      out_if.d_bits_source = 5'h03;
      step();
      out_if.d_valid = 1'b0;
      chk_cnt++; if (in_if.d_valid !== 1'b1 || in_if.d_bits_source !== 5'h03)
         $display("FAIL dres_new got v=%b src=%0d want v=1 src=3", in_if.d_valid, in_if.d_bits_source);
      else pass_cnt++;
      in_if.d_ready = 1'b1;
      step();
      chk_cnt++; if (in_if.d_valid !== 1'b0) $display("FAIL dres_empty got %b want 0", in_if.d_valid); else pass_cnt++;
   endtask

   task automatic test_random(input int cycles);
      logic [119:0] a_q[$];
      logic [81:0]  d_q[$];
      logic [119:0] a_exp;
      logic [81:0]  d_exp;
      logic         a_hold, d_hold;
      do_reset();
      a_hold = 1'b0;
      d_hold = 1'b0;
      for (int c = 0; c < cycles + 6; c++) begin
         if (c < cycles) begin
            if (!a_hold) begin in_if.a_valid = 1'($urandom); rand_a(); end
            if (!d_hold) begin out_if.d_valid = 1'($urandom); rand_d(); end
            out_if.a_ready = 1'($urandom);
            in_if.d_ready  = 1'($urandom);
         end else begin
            if (!a_hold) in_if.a_valid = 1'b0;
            if (!d_hold) out_if.d_valid = 1'b0;
            out_if.a_ready = 1'b1;
            in_if.d_ready  = 1'b1;
         end
         #3;
         a_hold = in_if.a_valid && !in_if.a_ready;
         d_hold = out_if.d_valid && !out_if.d_ready;
         if (in_if.a_valid && in_if.a_ready) a_q.push_back(pk_a_in());
         if (out_if.d_valid && out_if.d_ready) d_q.push_back(pk_d_in());
         if (out_if.a_valid && out_if.a_ready) begin
            chk_cnt++;
            if (a_q.size() == 0) $display("FAIL rand_a_extra cycle %0d got %h want none", c, pk_a_out());
            else begin
               a_exp = a_q.pop_front();
               if (pk_a_out() !== a_exp) $display("FAIL rand_a_data cycle %0d got %h want %h", c, pk_a_out(), a_exp);
               else pass_cnt++;
            end
         end
         if (in_if.d_valid && in_if.d_ready) begin
            chk_cnt++;
            if (d_q.size() == 0) $display("FAIL rand_d_extra cycle %0d got %h want none", c, pk_d_out());
            else begin
               d_exp = d_q.pop_front();
               if (pk_d_out() !== d_exp) $display("FAIL rand_d_data cycle %0d got %h want %h", c, pk_d_out(), d_exp);
               else pass_cnt++;
            end
         end
         step();
      end
      chk_cnt++; if (a_q.size() != 0 || out_if.a_valid !== 1'b0)
         $display("FAIL rand_a_loss got left=%0d v=%b want left=0 v=0", a_q.size(), out_if.a_valid);
      else pass_cnt++;
      chk_cnt++; if (d_q.size() != 0 || in_if.d_valid !== 1'b0)
         $display("FAIL rand_d_loss got left=%0d v=%b want left=0 v=0", d_q.size(), in_if.d_valid);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_a_single();
      test_a_full();
      test_burst();
`ifdef TL_BUFFER_D_FLOW_EN
      test_d_flow();
`else
      test_d_latency();
`endif
      test_d_reset_mid();
      test_random(10000);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
